// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus framed TX stream of the burst reader, bundled as one interface.
// Carries no logic and adds no latency.
// The reader side sees txReady as stream backpressure and drives fifoPop toward the FIFO.
interface fifo_burst_reader_if #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 10,
    parameter int LEN_W   = 9
) ();
    // FIFO read side (show-ahead: fifoDataOut is the head word whenever not empty)
    logic               fifoEmpty;
    logic [DATA_W-1:0]  fifoDataOut;
    logic [DEPTH_W-1:0] fifoDepth;
    logic               fifoPop;

    // Framed stream toward the TLP builder
    logic               txValid;
    logic               txReady;
    logic [DATA_W-1:0]  txData;
    logic               txSop;
    logic               txEop;
    logic [LEN_W-1:0]   txLen;

    // Burst reader's view
    modport master (
        input  fifoEmpty, fifoDataOut, fifoDepth, txReady,
        output fifoPop, txValid, txData, txSop, txEop, txLen
    );

    // FIFO and downstream consumer's view
    modport slave (
        output fifoEmpty, fifoDataOut, fifoDepth, txReady,
        input  fifoPop, txValid, txData, txSop, txEop, txLen
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into framed bursts once enough words are buffered (or on flush).
// Latency: start decision to first SOP word is two clocks; then one word per clock.
// Backpressure: a stalled txReady freezes the output register and suppresses fifoPop.
module fifo_burst_reader #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 10,
    parameter int LEN_W   = 9
) (
    input  logic                clockCore,
    input  logic                resetCore,
    input  logic                enable,
    input  logic                flush,
    input  logic [LEN_W-1:0]    burstLen,
    fifo_burst_reader_if.master bus,
    output logic                busy,
    output logic [15:0]         burstCount
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } stateType;

    stateType           state;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   txLenReg;
    logic [DATA_W-1:0]  txDataReg;
    logic               txValidReg;
    logic               txSopReg;
    logic               txEopReg;

    logic [LEN_W-1:0]   effLen;
    logic [DEPTH_W-1:0] effLenWide;
    logic [LEN_W-1:0]   shortLen;
    logic               startFull;
    logic               startShort;
    logic               pop;
    logic               accept;

    // Start conditions: a zero length request means one word; the occupancy
    // comparison is done at FIFO-depth width so a 256-word request is exact.
    // When flushing, fifoDepth < effLen <= 2^LEN_W-1, so the truncation to
    // LEN_W bits in the short length is lossless.
    always_comb begin
        effLen     = (burstLen == '0) ? LEN_W'(1) : burstLen;
        effLenWide = DEPTH_W'(effLen);
        shortLen   = (bus.fifoDepth < effLenWide) ? bus.fifoDepth[LEN_W-1:0] : effLen;
        startFull  = enable && (bus.fifoDepth >= effLenWide);
        startShort = enable && flush && !bus.fifoEmpty;
    end

    // Pop whenever the burst still owes words, data exists and the output slot frees up.
    always_comb begin
        accept = txValidReg && bus.txReady;
        pop    = (state == XFER) && (remaining != '0) && !bus.fifoEmpty
                 && (!txValidReg || bus.txReady);
    end

    // Burst FSM together with the output register and completed-burst counter.
    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            state      <= IDLE;
            remaining  <= '0;
            txLenReg   <= '0;
            txDataReg  <= '0;
            txValidReg <= 1'b0;
            txSopReg   <= 1'b0;
            txEopReg   <= 1'b0;
            burstCount <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (startFull) begin
                        txLenReg  <= effLen;
                        remaining <= effLen;
                        state     <= XFER;
                    end else if (startShort) begin
                        txLenReg  <= shortLen;
                        remaining <= shortLen;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    // EOP accepted: the burst is done, the next one is evaluated from IDLE
                    if (accept && txEopReg) begin
                        state      <= IDLE;
                        burstCount <= burstCount + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register: load the FIFO head on pop, otherwise retire an accepted word.
            // A pop only happens in XFER, so this never collides with the IDLE length load.
            if (pop) begin
                txDataReg  <= bus.fifoDataOut;
                txValidReg <= 1'b1;
                txSopReg   <= (remaining == txLenReg);
                txEopReg   <= (remaining == LEN_W'(1));
                remaining  <= remaining - LEN_W'(1);
            end else if (accept) begin
                txValidReg <= 1'b0;
                txSopReg   <= 1'b0;
                txEopReg   <= 1'b0;
            end
        end
    end

    assign bus.fifoPop = pop;
    assign bus.txValid = txValidReg;
    assign bus.txData  = txDataReg;
    assign bus.txSop   = txSopReg;
    assign bus.txEop   = txEopReg;
    assign bus.txLen   = txLenReg;
    assign busy        = (state == XFER);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO, burst-level reference model, random traffic.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
// txReady is driven constant, random or in a fixed stall pattern depending on the phase.
module tb_fifo_burst_reader;
    localparam int DATA_W   = 32;
    localparam int DEPTH_W  = 10;
    localparam int LEN_W    = 9;
    localparam int FIFO_CAP = 267;

    logic              clockCore = 1'b0;
    logic              resetCore = 1'b0;
    logic              enable    = 1'b0;
    logic              flush     = 1'b0;
    logic [LEN_W-1:0]  burstLen  = '0;
    logic              busy;
    logic [15:0]       burstCount;

    fifo_burst_reader_if #(.DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .LEN_W(LEN_W)) bus ();

    fifo_burst_reader #(.DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .LEN_W(LEN_W)) dut (
        .clockCore (clockCore),
        .resetCore (resetCore),
        .enable    (enable),
        .flush     (flush),
        .burstLen  (burstLen),
        .bus       (bus),
        .busy      (busy),
        .burstCount(burstCount)
    );

    always #5 clockCore = ~clockCore;

    // Scoreboard and reference model state
    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] fifoQ[$];      // FIFO contents
    logic [31:0] expQ[$];       // words the stream still owes, in push order
    bit          mBusy      = 0;
    int          mLen       = 0;
    int          mAcc       = 0;
    int          mPops      = 0;
    int          sinceStart = 0;
    logic [15:0] mCount     = 16'd0;
    int          pendLen    = 0;
    bit          sPop       = 0;
    bit          sAcc       = 0;
    bit          prevStall  = 0;
    logic [31:0] snapData;
    logic        snapSop, snapEop;
    logic [LEN_W-1:0] snapLen;
    int          lastDutLen = 0;
    int          pushProb   = 0;
    int          readyMode  = 0;
    int          readyPhase = 0;
    bit          drainMode  = 0;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] want);
        checkCount++;
        if (got === want) passCount++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic driveFifo();
        bus.fifoEmpty   = (fifoQ.size() == 0);
        bus.fifoDataOut = (fifoQ.size() != 0) ? fifoQ[0] : 32'd0;
        bus.fifoDepth   = DEPTH_W'(fifoQ.size());
    endtask

    task automatic pushWord(input logic [31:0] w);
        fifoQ.push_back(w);
        expQ.push_back(w);
        driveFifo();
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, ".fifoPop"}, bus.fifoPop, 0);
        checkValue({tag, ".txValid"}, bus.txValid, 0);
        checkValue({tag, ".txSop"}, bus.txSop, 0);
        checkValue({tag, ".txEop"}, bus.txEop, 0);
        checkValue({tag, ".txData"}, bus.txData, 0);
        checkValue({tag, ".txLen"}, bus.txLen, 0);
        checkValue({tag, ".busy"}, busy, 0);
        checkValue({tag, ".burstCount"}, burstCount, 0);
    endtask

    // Falling-edge observation: compare against the model, then decide what the
    // block must do at the coming rising edge from the burst-start rules.
    task automatic sampleCycle();
        bit popNow, accNow;
        int depth, effL;
        @(negedge clockCore);
        popNow  = bus.fifoPop;
        accNow  = bus.txValid && bus.txReady;
        pendLen = 0;
        checkValue("popWhenEmpty", popNow && bus.fifoEmpty, 0);
        checkValue("busy", busy, mBusy);
        checkValue("burstCount", burstCount, mCount);
        if (prevStall) begin
            checkValue("holdValid", bus.txValid, 1);
            checkValue("holdData", bus.txData, snapData);
            checkValue("holdSop", bus.txSop, snapSop);
            checkValue("holdEop", bus.txEop, snapEop);
            checkValue("holdLen", bus.txLen, snapLen);
        end
        if (bus.txValid && !bus.txReady) checkValue("popInStall", popNow, 0);
        if (!mBusy) begin
            checkValue("validWhileIdle", bus.txValid, 0);
        end else begin
            if (sinceStart == 0) checkValue("firstPop", popNow, 1);
            if (sinceStart == 1) checkValue("sopLatency", {bus.txValid, bus.txSop}, 2'b11);
            sinceStart++;
            if (bus.txValid) begin
                checkValue("txLen", bus.txLen, mLen);
                checkValue("txSop", bus.txSop, mAcc == 0);
                checkValue("txEop", bus.txEop, mAcc == mLen - 1);
            end
            if (popNow) checkValue("popBudget", mPops < mLen, 1);
        end
        if (accNow) begin
            checkValue("wordAvailable", expQ.size() != 0, 1);
            if (expQ.size() != 0) checkValue("txData", bus.txData, expQ[0]);
            if (bus.txEop) lastDutLen = int'(bus.txLen);
        end
        if (!mBusy && resetCore) begin
            depth = fifoQ.size();
            effL  = (burstLen == 0) ? 1 : int'(burstLen);
            if (enable && depth >= effL) pendLen = effL;
            else if (enable && flush && depth > 0) pendLen = (depth < effL) ? depth : effL;
        end
        prevStall = bus.txValid && !bus.txReady;
        snapData  = bus.txData;
        snapSop   = bus.txSop;
        snapEop   = bus.txEop;
        snapLen   = bus.txLen;
        sPop      = popNow;
        sAcc      = accNow;
    endtask

    // Rising edge: commit what the model predicted, then present new stimulus.
    task automatic applyEdge();
        logic [3:0] pattern;
        @(posedge clockCore);
        #1;
        if (sPop && fifoQ.size() != 0) begin
            void'(fifoQ.pop_front());
            mPops++;
        end
        if (sAcc) begin
            if (expQ.size() != 0) void'(expQ.pop_front());
            mAcc++;
            if (mAcc == mLen) begin
                checkValue("popsPerBurst", mPops, mLen);
                mBusy  = 0;
                mCount = mCount + 16'd1;
            end
        end
        if (pendLen != 0) begin
            mBusy      = 1;
            mLen       = pendLen;
            mAcc       = 0;
            mPops      = 0;
            sinceStart = 0;
        end
        if (drainMode) begin
            if (mBusy && (mLen - mPops) > fifoQ.size() && $urandom_range(99) < 50)
                pushWord($urandom);
        end else if (pushProb > 0 && fifoQ.size() < FIFO_CAP && $urandom_range(99) < pushProb) begin
            pushWord($urandom);
        end
        pattern = 4'b1001;
        case (readyMode)
            0:       bus.txReady = 1'b1;
            1:       bus.txReady = ($urandom_range(99) < 70);
            default: bus.txReady = pattern[3 - (readyPhase % 4)];
        endcase
        readyPhase++;
        driveFifo();
    endtask

    task automatic step();
        sampleCycle();
        applyEdge();
    endtask

    task automatic runUntilCount(input string tag, input int target, input int budget);
        int n = 0;
        while (int'(mCount) != target && n < budget) begin
            step();
            n++;
        end
        checkValue(tag, mCount, target);
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.txReady = 1'b1;
        driveFifo();
        #12;
        checkAllZero("reset");
        @(posedge clockCore);
        #1;
        resetCore = 1'b1;
        runIdle(2);

        // Basic: 0x1..0x8, two bursts of four
        for (int w = 1; w <= 8; w++) pushWord(32'(w));
        burstLen = 9'd4;
        enable   = 1'b1;
        runUntilCount("basicBursts", 2, 40);
        checkValue("basicLen", lastDutLen, 4);
        checkValue("basicEmpty", fifoQ.size(), 0);

        // Threshold hold-off: three words never start a four-word burst
        for (int w = 0; w < 3; w++) pushWord(32'h100 + 32'(w));
        runIdle(6);
        checkValue("holdoffBusy", busy, 0);
        pushWord(32'h103);
        runUntilCount("thresholdBurst", 3, 20);

        // Flush: short burst of whatever is buffered
        enable = 1'b0;
        burstLen = 9'd16;
        for (int w = 0; w < 3; w++) pushWord(32'h200 + 32'(w));
        runIdle(2);
        flush  = 1'b1;
        enable = 1'b1;
        runUntilCount("flushBurst", 4, 20);
        flush = 1'b0;
        checkValue("flushLen", lastDutLen, 3);
        checkValue("flushEmpty", fifoQ.size(), 0);

        // Backpressure: ready pattern 1,0,0,1
        enable = 1'b0;
        burstLen = 9'd4;
        for (int w = 0; w < 4; w++) pushWord(32'h300 + 32'(w));
        readyMode  = 2;
        readyPhase = 0;
        runIdle(1);
        enable = 1'b1;
        runUntilCount("backpressureBurst", 5, 40);
        readyMode = 0;

        // burstLen = 0 behaves as single-word bursts
        burstLen = 9'd0;
        for (int w = 0; w < 3; w++) pushWord(32'h400 + 32'(w));
        runUntilCount("zeroLenBursts", 8, 30);
        checkValue("zeroLen", lastDutLen, 1);

        // 256-word burst from a full FIFO
        enable = 1'b0;
        burstLen = 9'h100;
        for (int w = 0; w < FIFO_CAP; w++) pushWord($urandom);
        runIdle(1);
        enable = 1'b1;
        runUntilCount("longBurst", 9, 400);
        runIdle(3);
        checkValue("longDepthLeft", fifoQ.size(), 11);
        checkValue("longLen", lastDutLen, 256);
        burstLen = 9'd11;
        runUntilCount("drainEleven", 10, 30);

        // Reset in the middle of a four-word burst
        enable = 1'b0;
        burstLen = 9'd4;
        for (int w = 0; w < 4; w++) pushWord(32'h500 + 32'(w));
        enable = 1'b1;
        n = 0;
        while (!(mBusy && mAcc >= 2) && n < 20) begin
            step();
            n++;
        end
        checkValue("reachedSecondWord", mAcc >= 2, 1);
        resetCore = 1'b0;
        #1;
        checkAllZero("midReset");
        repeat (mPops - mAcc) if (expQ.size() != 0) void'(expQ.pop_front());
        mBusy     = 0;
        mCount    = 16'd0;
        prevStall = 0;
        enable    = 1'b0;
        step();
        resetCore = 1'b1;
        runIdle(5);
        enable = 1'b1;
        flush  = 1'b1;
        runUntilCount("postResetFlush", 1, 20);
        flush = 1'b0;

        // Random traffic
        pushProb  = 60;
        readyMode = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) begin
                int r;
                enable = ($urandom_range(99) < 80);
                flush  = ($urandom_range(99) < 30);
                r = $urandom_range(9);
                if (r < 7)       burstLen = LEN_W'($urandom_range(0, 12));
                else if (r == 7) burstLen = LEN_W'($urandom_range(13, 64));
                else if (r == 8) burstLen = 9'h100;
                else             burstLen = 9'd1;
            end
            step();
        end

        // Drain everything that is left
        drainMode = 1;
        enable    = 1'b1;
        flush     = 1'b1;
        burstLen  = 9'd16;
        n = 0;
        while ((fifoQ.size() != 0 || mBusy) && n < 3000) begin
            step();
            n++;
        end
        checkValue("drained", (fifoQ.size() == 0) && !mBusy, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
